// File: rtl/flash_phy_pkg.sv
// Shared types and default sizing for the flash PHY read-buffer
// dependency tracker.
package flash_phy_pkg;

  localparam int NumBufDef   = 4;
  localparam int RspDepthDef = 4;

  typedef enum logic [1:0] {
    DRN_IDLE  = 2'd0,
    DRN_DRAIN = 2'd1,
    DRN_ACK   = 2'd2
  } drain_st_e;

endpackage

// File: rtl/flash_phy_rd_buf_dep_trk_if.sv
// Response-queue push/pop, drain and status bundle for the
// read-buffer dependency tracker.
interface flash_phy_rd_buf_dep_trk_if
  import flash_phy_pkg::*;
#(
  parameter int NumBuf   = NumBufDef,
  parameter int RspDepth = RspDepthDef
);
  localparam int IdxW = $clog2(NumBuf);
  localparam int CntW = $clog2(RspDepth + 1);

  logic              en_i;
  logic              wr_i;
  logic [IdxW-1:0]   wr_idx_i;
  logic              rd_i;
  logic [IdxW-1:0]   rd_idx_i;
  logic              flush_i;
  logic              drain_req_i;
  logic              drain_ack_o;
  logic              wr_block_o;
  logic [NumBuf-1:0] dependency_o;
  logic              all_dependency_o;
  logic              free_vld_o;
  logic [IdxW-1:0]   free_idx_o;
  logic [CntW-1:0]   total_cnt_o;
  logic              err_ovf_o;
  logic              err_udf_o;
  logic              err_idx_o;

  modport master (
    output en_i, wr_i, wr_idx_i, rd_i, rd_idx_i,
    output flush_i, drain_req_i,
    input  drain_ack_o, wr_block_o, dependency_o,
    input  all_dependency_o, free_vld_o, free_idx_o,
    input  total_cnt_o, err_ovf_o, err_udf_o, err_idx_o
  );

  modport slave (
    input  en_i, wr_i, wr_idx_i, rd_i, rd_idx_i,
    input  flush_i, drain_req_i,
    output drain_ack_o, wr_block_o, dependency_o,
    output all_dependency_o, free_vld_o, free_idx_o,
    output total_cnt_o, err_ovf_o, err_udf_o, err_idx_o
  );

endinterface

// File: rtl/flash_phy_rd_buf_dep_penc.sv
// Lowest-set-bit priority encoder; used to pick the lowest
// read buffer with no outstanding responses.
module flash_phy_rd_buf_dep_penc #(
  parameter int Width = 4,
  localparam int IdxW = $clog2(Width)
) (
  input  logic [Width-1:0] req_i,
  output logic             vld_o,
  output logic [IdxW-1:0]  idx_o
);

  always_comb begin
    vld_o = |req_i;
    idx_o = '0;
    for (int i = Width - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IdxW'(i);
    end
  end

endmodule

// File: rtl/flash_phy_rd_buf_dep_trk.sv
// Per-buffer outstanding-response counters with overflow/underflow
// checking, lowest-free selection and a drain/quiesce handshake.
module flash_phy_rd_buf_dep_trk
  import flash_phy_pkg::*;
#(
  parameter int NumBuf   = NumBufDef,
  parameter int RspDepth = RspDepthDef
) (
  input logic clk_i,
  input logic rst_ni,
  flash_phy_rd_buf_dep_trk_if.slave bus
);

  localparam int IdxW = $clog2(NumBuf);
  localparam int CntW = $clog2(RspDepth + 1);
  localparam logic [CntW-1:0] Full = CntW'(RspDepth);
  localparam logic [IdxW:0] NbLim = (IdxW+1)'(NumBuf);
  localparam logic [CntW-1:0] One = CntW'(1);

  logic [CntW-1:0] cnt_q [NumBuf];
  logic [CntW-1:0] cnt_d [NumBuf];
  logic [CntW-1:0] total_q, total_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;
  logic            idxe_q, idxe_d;
  drain_st_e       st_q, st_d;
  logic            ack_q, ack_d;
  logic            blk_q, blk_d;

  logic            wr_in, rd_in;
  logic            wr_ok, rd_ok;
  logic [CntW-1:0] wr_cnt, rd_cnt;
  logic [NumBuf-1:0] dep;
  logic            free_vld;
  logic [IdxW-1:0] free_idx;

  always_comb begin
    wr_in  = {1'b0, bus.wr_idx_i} < NbLim;
    rd_in  = {1'b0, bus.rd_idx_i} < NbLim;
    wr_cnt = '0;
    rd_cnt = '0;
    for (int i = 0; i < NumBuf; i++) begin
      if (bus.wr_idx_i == IdxW'(i)) wr_cnt = cnt_q[i];
      if (bus.rd_idx_i == IdxW'(i)) rd_cnt = cnt_q[i];
    end
    wr_ok = bus.en_i & bus.wr_i & ~blk_q & wr_in
          & (wr_cnt < Full) & (total_q < Full);
    rd_ok = bus.en_i & bus.rd_i & rd_in & (rd_cnt != '0);
  end

  // Same-index push+pop cancels naturally: +1 then -1.
  always_comb begin
    for (int i = 0; i < NumBuf; i++) begin
      cnt_d[i] = cnt_q[i];
      if (wr_ok && bus.wr_idx_i == IdxW'(i))
        cnt_d[i] = cnt_d[i] + One;
      if (rd_ok && bus.rd_idx_i == IdxW'(i))
        cnt_d[i] = cnt_d[i] - One;
      if (bus.flush_i) cnt_d[i] = '0;
    end
    total_d = total_q;
    if (wr_ok) total_d = total_d + One;
    if (rd_ok) total_d = total_d - One;
    ovf_d  = ovf_q | (bus.en_i & bus.wr_i & ~blk_q & wr_in
           & ((wr_cnt >= Full) | (total_q >= Full)));
    udf_d  = udf_q | (bus.en_i & bus.rd_i & rd_in
           & (rd_cnt == '0));
    idxe_d = idxe_q | (bus.en_i
           & ((bus.wr_i & ~blk_q & ~wr_in)
           | (bus.rd_i & ~rd_in)));
    if (bus.flush_i) begin
      total_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
      idxe_d  = 1'b0;
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      DRN_IDLE:  if (bus.drain_req_i) st_d = DRN_DRAIN;
      DRN_DRAIN: if (total_q == '0) st_d = DRN_ACK;
      DRN_ACK:   st_d = DRN_IDLE;
      default:   st_d = DRN_IDLE;
    endcase
    if (bus.flush_i) st_d = DRN_IDLE;
    blk_d = (st_d != DRN_IDLE);
    ack_d = (st_d == DRN_ACK);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumBuf; i++) cnt_q[i] <= '0;
      total_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      idxe_q  <= 1'b0;
      st_q    <= DRN_IDLE;
      ack_q   <= 1'b0;
      blk_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NumBuf; i++) cnt_q[i] <= cnt_d[i];
      total_q <= total_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      idxe_q  <= idxe_d;
      st_q    <= st_d;
      ack_q   <= ack_d;
      blk_q   <= blk_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NumBuf; i++) dep[i] = (cnt_q[i] != '0);
  end

  flash_phy_rd_buf_dep_penc #(
    .Width (NumBuf)
  ) u_penc (
    .req_i (~dep),
    .vld_o (free_vld),
    .idx_o (free_idx)
  );

  assign bus.dependency_o     = dep;
  assign bus.all_dependency_o = &dep;
  assign bus.free_vld_o       = free_vld;
  assign bus.free_idx_o       = free_idx;
  assign bus.total_cnt_o      = total_q;
  assign bus.err_ovf_o        = ovf_q;
  assign bus.err_udf_o        = udf_q;
  assign bus.err_idx_o        = idxe_q;
  assign bus.drain_ack_o      = ack_q;
  assign bus.wr_block_o       = blk_q;

  int sum_c;
  always_comb begin
    sum_c = 0;
    for (int i = 0; i < NumBuf; i++) sum_c += int'(cnt_q[i]);
  end

  a_sum : assert property (@(posedge clk_i) disable iff (!rst_ni)
    int'(total_q) == sum_c);
  a_cap : assert property (@(posedge clk_i) disable iff (!rst_ni)
    total_q <= Full);
  a_nodep : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (NumBuf > RspDepth) |-> !(&dep));
  a_ack : assert property (@(posedge clk_i) disable iff (!rst_ni)
    ack_q |=> !ack_q);

endmodule

// File: tb/tb_flash_phy_rd_buf_dep_trk.sv
// Directed bench for the read-buffer dependency tracker: default
// sizing plus two alternate parameter sets.
module tb_flash_phy_rd_buf_dep_trk;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  flash_phy_rd_buf_dep_trk_if #(.NumBuf(4), .RspDepth(4)) b0 ();
  flash_phy_rd_buf_dep_trk_if #(.NumBuf(8), .RspDepth(2)) b1 ();
  flash_phy_rd_buf_dep_trk_if #(.NumBuf(6), .RspDepth(2)) b2 ();

  flash_phy_rd_buf_dep_trk #(.NumBuf(4), .RspDepth(4)) u0 (
    .clk_i(clk), .rst_ni(rst_ni), .bus(b0));
  flash_phy_rd_buf_dep_trk #(.NumBuf(8), .RspDepth(2)) u1 (
    .clk_i(clk), .rst_ni(rst_ni), .bus(b1));
  flash_phy_rd_buf_dep_trk #(.NumBuf(6), .RspDepth(2)) u2 (
    .clk_i(clk), .rst_ni(rst_ni), .bus(b2));

  task automatic idle();
    b0.en_i = 1; b0.wr_i = 0; b0.wr_idx_i = 0; b0.rd_i = 0;
    b0.rd_idx_i = 0; b0.flush_i = 0; b0.drain_req_i = 0;
    b1.en_i = 1; b1.wr_i = 0; b1.wr_idx_i = 0; b1.rd_i = 0;
    b1.rd_idx_i = 0; b1.flush_i = 0; b1.drain_req_i = 0;
    b2.en_i = 1; b2.wr_i = 0; b2.wr_idx_i = 0; b2.rd_i = 0;
    b2.rd_idx_i = 0; b2.flush_i = 0; b2.drain_req_i = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic flush0();
    b0.flush_i = 1; cyc(); b0.flush_i = 0;
  endtask

  task automatic test_reset();
    rst_ni = 0; idle(); cyc(); cyc();
    total++; if (b0.dependency_o !== 4'b0000) begin bad++;
      $display("FAIL rst_dep got=%b exp=0000", b0.dependency_o); end
    total++; if (b0.all_dependency_o !== 1'b0) begin bad++;
      $display("FAIL rst_all got=%b exp=0", b0.all_dependency_o); end
    total++; if (b0.free_vld_o !== 1'b1) begin bad++;
      $display("FAIL rst_fvld got=%b exp=1", b0.free_vld_o); end
    total++; if (b0.free_idx_o !== 2'd0) begin bad++;
      $display("FAIL rst_fidx got=%0d exp=0", b0.free_idx_o); end
    total++; if (b0.total_cnt_o !== 3'd0) begin bad++;
      $display("FAIL rst_tot got=%0d exp=0", b0.total_cnt_o); end
    total++; if ({b0.err_ovf_o, b0.err_udf_o, b0.err_idx_o} !== 3'b000)
      begin bad++; $display("FAIL rst_err got=%b%b%b exp=000",
        b0.err_ovf_o, b0.err_udf_o, b0.err_idx_o); end
    total++; if ({b0.drain_ack_o, b0.wr_block_o} !== 2'b00) begin bad++;
      $display("FAIL rst_drn got=%b%b exp=00",
        b0.drain_ack_o, b0.wr_block_o); end
    rst_ni = 1; cyc();
  endtask

  task automatic test_push_pop();
    b0.wr_i = 1; b0.wr_idx_i = 2;
    repeat (4) cyc();
    b0.wr_i = 0; b0.rd_i = 1; b0.rd_idx_i = 2; cyc();
    b0.rd_i = 0;
    total++; if (b0.total_cnt_o !== 3'd3) begin bad++;
      $display("FAIL pp_tot got=%0d exp=3", b0.total_cnt_o); end
    total++; if (b0.dependency_o !== 4'b0100) begin bad++;
      $display("FAIL pp_dep got=%b exp=0100", b0.dependency_o); end
    total++; if (b0.free_idx_o !== 2'd0) begin bad++;
      $display("FAIL pp_fidx got=%0d exp=0", b0.free_idx_o); end
    total++; if (b0.err_ovf_o !== 1'b0) begin bad++;
      $display("FAIL pp_ovf got=%b exp=0", b0.err_ovf_o); end
    flush0();
  endtask

  task automatic test_overflow();
    b0.wr_i = 1;
    b0.wr_idx_i = 0; cyc();
    b0.wr_idx_i = 1; cyc();
    total++; if (b0.free_idx_o !== 2'd2) begin bad++;
      $display("FAIL ovf_fidx2 got=%0d exp=2", b0.free_idx_o); end
    b0.wr_idx_i = 2; cyc();
    b0.wr_idx_i = 3; cyc();
    b0.wr_i = 0;
    total++; if (b0.all_dependency_o !== 1'b1) begin bad++;
      $display("FAIL ovf_all got=%b exp=1", b0.all_dependency_o); end
    total++; if (b0.free_vld_o !== 1'b0) begin bad++;
      $display("FAIL ovf_fvld got=%b exp=0", b0.free_vld_o); end
    total++; if (b0.free_idx_o !== 2'd0) begin bad++;
      $display("FAIL ovf_fidx got=%0d exp=0", b0.free_idx_o); end
    total++; if (b0.err_ovf_o !== 1'b0) begin bad++;
      $display("FAIL ovf_pre got=%b exp=0", b0.err_ovf_o); end
    b0.wr_i = 1; b0.wr_idx_i = 1; cyc(); b0.wr_i = 0;
    total++; if (b0.err_ovf_o !== 1'b1) begin bad++;
      $display("FAIL ovf_err got=%b exp=1", b0.err_ovf_o); end
    total++; if (b0.total_cnt_o !== 3'd4) begin bad++;
      $display("FAIL ovf_tot got=%0d exp=4", b0.total_cnt_o); end
    cyc();
    total++; if (b0.err_ovf_o !== 1'b1) begin bad++;
      $display("FAIL ovf_sticky got=%b exp=1", b0.err_ovf_o); end
    flush0();
    total++; if ({b0.err_ovf_o, b0.total_cnt_o} !== 4'b0_000) begin bad++;
      $display("FAIL ovf_flush got=%b/%0d exp=0/0",
        b0.err_ovf_o, b0.total_cnt_o); end
  endtask

  task automatic test_underflow();
    b0.wr_i = 1; b0.wr_idx_i = 0; cyc(); b0.wr_i = 0;
    b0.rd_i = 1; b0.rd_idx_i = 3; cyc(); b0.rd_i = 0;
    total++; if (b0.err_udf_o !== 1'b1) begin bad++;
      $display("FAIL udf_err got=%b exp=1", b0.err_udf_o); end
    total++; if (b0.total_cnt_o !== 3'd1) begin bad++;
      $display("FAIL udf_tot got=%0d exp=1", b0.total_cnt_o); end
    total++; if (b0.dependency_o !== 4'b0001) begin bad++;
      $display("FAIL udf_dep got=%b exp=0001", b0.dependency_o); end
    flush0();
    total++; if (b0.err_udf_o !== 1'b0) begin bad++;
      $display("FAIL udf_flush got=%b exp=0", b0.err_udf_o); end
    total++; if (b0.total_cnt_o !== 3'd0) begin bad++;
      $display("FAIL udf_ftot got=%0d exp=0", b0.total_cnt_o); end
    total++; if (b0.dependency_o !== 4'b0000) begin bad++;
      $display("FAIL udf_fdep got=%b exp=0000", b0.dependency_o); end
  endtask

  task automatic test_same_cycle();
    b0.wr_i = 1; b0.wr_idx_i = 1; cyc();
    b0.rd_i = 1; b0.rd_idx_i = 1; cyc();
    total++; if (b0.total_cnt_o !== 3'd1) begin bad++;
      $display("FAIL sc_tot got=%0d exp=1", b0.total_cnt_o); end
    total++; if (b0.dependency_o !== 4'b0010) begin bad++;
      $display("FAIL sc_dep got=%b exp=0010", b0.dependency_o); end
    total++; if ({b0.err_ovf_o, b0.err_udf_o, b0.err_idx_o} !== 3'b000)
      begin bad++; $display("FAIL sc_err got=%b%b%b exp=000",
        b0.err_ovf_o, b0.err_udf_o, b0.err_idx_o); end
    b0.wr_idx_i = 2; cyc();
    b0.wr_i = 0; b0.rd_i = 0;
    total++; if (b0.total_cnt_o !== 3'd1) begin bad++;
      $display("FAIL sc2_tot got=%0d exp=1", b0.total_cnt_o); end
    total++; if (b0.dependency_o !== 4'b0100) begin bad++;
      $display("FAIL sc2_dep got=%b exp=0100", b0.dependency_o); end
    flush0();
  endtask

  task automatic test_enable();
    b0.en_i = 0; b0.wr_i = 1; b0.wr_idx_i = 0;
    b0.rd_i = 1; b0.rd_idx_i = 3; cyc();
    b0.en_i = 1; b0.wr_i = 0; b0.rd_i = 0;
    total++; if (b0.total_cnt_o !== 3'd0) begin bad++;
      $display("FAIL en_tot got=%0d exp=0", b0.total_cnt_o); end
    total++; if (b0.err_udf_o !== 1'b0) begin bad++;
      $display("FAIL en_udf got=%b exp=0", b0.err_udf_o); end
  endtask

  task automatic test_drain();
    b0.wr_i = 1; b0.wr_idx_i = 0; cyc();
    b0.wr_idx_i = 1; cyc(); b0.wr_i = 0;
    b0.drain_req_i = 1; cyc(); b0.drain_req_i = 0;
    total++; if ({b0.wr_block_o, b0.drain_ack_o} !== 2'b10) begin bad++;
      $display("FAIL dr_blk got=%b%b exp=10",
        b0.wr_block_o, b0.drain_ack_o); end
    b0.wr_i = 1; b0.wr_idx_i = 2; cyc(); b0.wr_i = 0;
    total++; if (b0.total_cnt_o !== 3'd2) begin bad++;
      $display("FAIL dr_ign got=%0d exp=2", b0.total_cnt_o); end
    total++; if (b0.err_ovf_o !== 1'b0) begin bad++;
      $display("FAIL dr_noerr got=%b exp=0", b0.err_ovf_o); end
    b0.rd_i = 1; b0.rd_idx_i = 0; cyc();
    b0.rd_idx_i = 1; cyc(); b0.rd_i = 0;
    total++; if ({b0.total_cnt_o, b0.drain_ack_o} !== 4'b000_0)
      begin bad++; $display("FAIL dr_zero got=%0d/%b exp=0/0",
        b0.total_cnt_o, b0.drain_ack_o); end
    cyc();
    total++; if ({b0.wr_block_o, b0.drain_ack_o} !== 2'b11) begin bad++;
      $display("FAIL dr_ack got=%b%b exp=11",
        b0.wr_block_o, b0.drain_ack_o); end
    cyc();
    total++; if ({b0.wr_block_o, b0.drain_ack_o} !== 2'b00) begin bad++;
      $display("FAIL dr_end got=%b%b exp=00",
        b0.wr_block_o, b0.drain_ack_o); end
  endtask

  task automatic test_drain_idle();
    b0.drain_req_i = 1; cyc(); b0.drain_req_i = 0;
    total++; if ({b0.wr_block_o, b0.drain_ack_o} !== 2'b10) begin bad++;
      $display("FAIL di_1 got=%b%b exp=10",
        b0.wr_block_o, b0.drain_ack_o); end
    cyc();
    total++; if (b0.drain_ack_o !== 1'b1) begin bad++;
      $display("FAIL di_2 got=%b exp=1", b0.drain_ack_o); end
    cyc();
    total++; if (b0.drain_ack_o !== 1'b0) begin bad++;
      $display("FAIL di_3 got=%b exp=0", b0.drain_ack_o); end
    b0.drain_req_i = 1; b0.flush_i = 1;
    b0.wr_i = 1; b0.wr_idx_i = 3; cyc(); idle();
    total++; if ({b0.wr_block_o, b0.total_cnt_o} !== 4'b0_000)
      begin bad++; $display("FAIL fl_prio got=%b/%0d exp=0/0",
        b0.wr_block_o, b0.total_cnt_o); end
  endtask

  task automatic test_reset_mid_drain();
    b0.wr_i = 1; b0.wr_idx_i = 0; cyc(); b0.wr_i = 0;
    b0.drain_req_i = 1; cyc(); b0.drain_req_i = 0;
    rst_ni = 0; cyc();
    total++; if ({b0.wr_block_o, b0.drain_ack_o} !== 2'b00) begin bad++;
      $display("FAIL rmd_st got=%b%b exp=00",
        b0.wr_block_o, b0.drain_ack_o); end
    total++; if (b0.total_cnt_o !== 3'd0) begin bad++;
      $display("FAIL rmd_tot got=%0d exp=0", b0.total_cnt_o); end
    rst_ni = 1; cyc(); cyc();
    total++; if (b0.drain_ack_o !== 1'b0) begin bad++;
      $display("FAIL rmd_ack got=%b exp=0", b0.drain_ack_o); end
  endtask

  task automatic test_params();
    b1.wr_i = 1; b1.wr_idx_i = 3'd7; cyc(); b1.wr_i = 0;
    total++; if (b1.dependency_o !== 8'h80) begin bad++;
      $display("FAIL p8_dep got=%b exp=10000000", b1.dependency_o); end
    total++; if (b1.free_idx_o !== 3'd0) begin bad++;
      $display("FAIL p8_fidx got=%0d exp=0", b1.free_idx_o); end
    b1.wr_i = 1; cyc();
    b1.wr_idx_i = 3'd6; cyc(); b1.wr_i = 0;
    total++; if (b1.total_cnt_o !== 2'd2) begin bad++;
      $display("FAIL p8_tot got=%0d exp=2", b1.total_cnt_o); end
    total++; if (b1.err_ovf_o !== 1'b1) begin bad++;
      $display("FAIL p8_ovf got=%b exp=1", b1.err_ovf_o); end
    b2.wr_i = 1; b2.wr_idx_i = 3'd7; cyc(); b2.wr_i = 0;
    total++; if (b2.err_idx_o !== 1'b1) begin bad++;
      $display("FAIL p6_idx got=%b exp=1", b2.err_idx_o); end
    total++; if ({b2.dependency_o, b2.total_cnt_o} !== 8'h00) begin bad++;
      $display("FAIL p6_drop got=%b/%0d exp=0/0",
        b2.dependency_o, b2.total_cnt_o); end
    total++; if (b0.err_idx_o !== 1'b0) begin bad++;
      $display("FAIL p4_idx got=%b exp=0", b0.err_idx_o); end
  endtask

  initial begin
    idle();
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_same_cycle();
    test_enable();
    test_drain();
    test_drain_idle();
    test_reset_mid_drain();
    test_params();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
